// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register, stall/redirect handling and bubble insertion.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              fetch_vld_q, fetch_vld_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   imem_addr_c;
  logic              misaligned_c;

  // Next-state, fetch address and IF/ID update
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_vld_d  = fetch_vld_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    imem_addr_c  = fetch_pc_q;
    misaligned_c = (redirect_pc_i[1:0] != 2'b00);

    unique case (state_q)
      S_BOOT: begin
        imem_addr_c = RESET_PC;
        state_d     = S_RUN;
        fetch_pc_d  = RESET_PC;
        fetch_vld_d = 1'b1;
      end
      S_RUN: begin
        if (redirect_i) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = fetch_pc_q;
          if (misaligned_c) begin
            // Fetch address freezes where it was; only reset leaves HALT
            state_d     = S_HALT;
            fault_d     = 1'b1;
            imem_addr_c = fetch_pc_q;
          end else begin
            imem_addr_c = redirect_pc_i;
            fetch_vld_d = 1'b1;
          end
        end else if (stall_i) begin
          imem_addr_c = fetch_pc_q;
        end else begin
          imem_addr_c = fetch_pc_q + XLEN'(4);
          instr_d     = imem_rdata_i;
          pc_d        = fetch_pc_q;
          valid_d     = fetch_vld_q;
        end
        fetch_pc_d = imem_addr_c;
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State and IF/ID registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      fetch_vld_q <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      fetch_vld_q <= fetch_vld_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;

  // Delivered-instruction and squash counters, wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      if (valid_q && !stall_i) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (redirect_i)          flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign imem_addr_o = imem_addr_c;
  assign instr_o     = instr_q;
  assign opcode_o    = instr_q[6:0];
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + XLEN'(4);
  assign valid_o     = valid_q;
  assign fault_o     = fault_q;

endmodule
